// File: rtl/tx_stream_scheduler.sv
// Round-robin packet scheduler sharing the 32-bit tx datapath between N_STREAMS sources.
// One word per gearbox gen_en slot; grants at packet boundaries, optional inter-packet gap, underrun drain.
module tx_stream_scheduler #(
   parameter int unsigned N_STREAMS = 4,
   parameter int unsigned SW        = 2,
   parameter int unsigned GAP_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    gen_en,
   input  logic [N_STREAMS-1:0]    cfg_en,
   input  logic [GAP_W-1:0]        cfg_gap,
   input  logic [N_STREAMS-1:0]    src_valid,
   input  logic [32*N_STREAMS-1:0] src_data,
   input  logic [N_STREAMS-1:0]    src_sop,
   input  logic [N_STREAMS-1:0]    src_eop,
   input  logic [2*N_STREAMS-1:0]  src_mod,
   output logic [N_STREAMS-1:0]    src_rd,
   output logic [31:0]             int_data_o,
   output logic                    int_valid_o,
   output logic                    int_sop_o,
   output logic                    int_eop_o,
   output logic [1:0]              int_mod_o,
   output logic [SW-1:0]           cur_stream,
   output logic                    busy,
   output logic                    underrun_o
);

   localparam int unsigned DW = 32;
   localparam int unsigned MW = 2;

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP, S_DRAIN} state_t;

   state_t               r_state, w_state_nxt, w_after_eop;
   logic [SW-1:0]        r_last_grant, r_cur;
   logic [GAP_W-1:0]     r_gap_cnt, w_gap_nxt;
   logic [DW-1:0]        r_data, w_data;
   logic [MW-1:0]        r_mod, w_mod;
   logic                 r_valid, r_sop, r_eop, r_underrun;
   logic                 w_issue, w_sop, w_eop, w_underrun, w_grant;
   logic [N_STREAMS-1:0] w_req, w_stray, w_rd;
   logic                 w_win_found;
   logic [SW-1:0]        w_win, w_idx;
   logic [DW-1:0]        w_src_word [N_STREAMS];
   logic [MW-1:0]        w_src_mod  [N_STREAMS];

   assign w_req       = cfg_en & src_valid & src_sop;
   assign w_stray     = cfg_en & src_valid & ~src_sop;
   assign w_after_eop = (cfg_gap != '0) ? S_GAP : S_IDLE;

   // Unpack the flat source buses into per-stream views.
   always_comb begin
      for (int i = 0; i < int'(N_STREAMS); i++) begin
         w_src_word[i] = src_data[i*DW +: DW];
         w_src_mod[i]  = src_mod[i*MW +: MW];
      end
   end

   // Round-robin search starting one past the last granted stream.
   always_comb begin
      w_win_found = 1'b0;
      w_win       = '0;
      w_idx       = '0;
      for (int unsigned k = 1; k <= N_STREAMS; k++) begin
         w_idx = SW'((32'(r_last_grant) + k) % N_STREAMS);
         if (!w_win_found && w_req[w_idx]) begin
            w_win_found = 1'b1;
            w_win       = w_idx;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      w_rd        = '0;
      w_issue     = 1'b0;
      w_data      = '0;
      w_sop       = 1'b0;
      w_eop       = 1'b0;
      w_mod       = '0;
      w_underrun  = 1'b0;
      w_grant     = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Heads without sop can never start a packet; discard them continuously.
            w_rd = w_stray;
            if (gen_en && w_win_found) begin
               w_grant     = 1'b1;
               w_rd[w_win] = 1'b1;
               w_issue     = 1'b1;
               w_data      = w_src_word[w_win];
               w_sop       = 1'b1;
               w_eop       = src_eop[w_win];
               w_mod       = w_src_mod[w_win];
               if (src_eop[w_win]) begin
                  w_gap_nxt   = cfg_gap;
                  w_state_nxt = w_after_eop;
               end else begin
                  w_state_nxt = S_XFER;
               end
            end
         end
         S_XFER: begin
            if (gen_en) begin
               w_issue = 1'b1;
               if (src_valid[r_cur]) begin
                  w_rd[r_cur] = 1'b1;
                  w_data      = w_src_word[r_cur];
                  w_eop       = src_eop[r_cur];
                  w_mod       = w_src_mod[r_cur];
                  if (src_eop[r_cur]) begin
                     w_gap_nxt   = cfg_gap;
                     w_state_nxt = w_after_eop;
                  end
               end else begin
                  // Source ran dry: close the packet downstream with a zero eop word.
                  w_eop       = 1'b1;
                  w_underrun  = 1'b1;
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            w_rd[r_cur] = src_valid[r_cur];
            if (src_valid[r_cur] && src_eop[r_cur]) begin
               w_gap_nxt   = cfg_gap;
               w_state_nxt = w_after_eop;
            end
         end
         S_GAP: begin
            if (gen_en) begin
               if (r_gap_cnt <= GAP_W'(1)) begin
                  w_gap_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_gap_nxt = r_gap_cnt - GAP_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_gap_cnt    <= '0;
         r_last_grant <= SW'(N_STREAMS - 1);
         r_cur        <= '0;
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_sop        <= 1'b0;
         r_eop        <= 1'b0;
         r_mod        <= '0;
         r_underrun   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gap_cnt  <= w_gap_nxt;
         r_valid    <= w_issue;
         r_underrun <= w_underrun;
         if (w_grant) begin
            r_last_grant <= w_win;
            r_cur        <= w_win;
         end
         if (w_issue) begin
            r_data <= w_data;
            r_sop  <= w_sop;
            r_eop  <= w_eop;
            r_mod  <= w_mod;
         end
      end
   end

   // Pops are suppressed while reset is held so no source word is lost.
   assign src_rd      = rst ? '0 : w_rd;
   assign int_data_o  = r_data;
   assign int_valid_o = r_valid;
   assign int_sop_o   = r_sop;
   assign int_eop_o   = r_eop;
   assign int_mod_o   = r_mod;
   assign cur_stream  = r_cur;
   assign busy        = (r_state != S_IDLE);
   assign underrun_o  = r_underrun;

endmodule
